mont_mult_core: RTL and testbench

//  Bit-serial radix-2 Montgomery multiplier: result = A*B*2^(-WORD_LEN) mod M.

---
 rtl/rsa_defs.sv | 27 ++
 rtl/mont_iter_step.sv | 29 ++
 rtl/mont_mult_core.sv | 109 ++++++++++
 tb/tb_mont_mult_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_defs.sv
// Shared RSA definitions for the Montgomery datapath and its wrapper.
//   - State encoding of the multiplier FSM (IDLE, LOOP, SUB, DONE).
//   - Default operand width.
//   - Wrapper command codes 1..5.
package rsa_defs;

  localparam int DEFAULT_WORD_LEN = 512;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOOP = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOOP = ST_LOOP,
    SUB  = ST_SUB,
    DONE = ST_DONE
  } state_e;

  localparam logic [2:0] CMD_READ_A  = 3'd1;
  localparam logic [2:0] CMD_READ_B  = 3'd2;
  localparam logic [2:0] CMD_READ_M  = 3'd3;
  localparam logic [2:0] CMD_COMPUTE = 3'd4;
  localparam logic [2:0] CMD_WRITE   = 3'd5;

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration, purely combinational.
//   c      : running accumulator C (WORD_LEN+1 bits, C < 2M)
//   b      : multiplier B
//   m      : modulus M (odd)
//   a_bit  : current bit of multiplicand A
//   c_next : (C + a_bit*B + q*M) / 2, where q makes the sum even
module mont_iter_step #(
  parameter int WORD_LEN = 512
) (
  input  logic [WORD_LEN:0]   c,
  input  logic [WORD_LEN-1:0] b,
  input  logic [WORD_LEN-1:0] m,
  input  logic                a_bit,
  output logic [WORD_LEN:0]   c_next
);

  // Both sums are kept at WORD_LEN+2 bits: C < 2M plus B plus M can reach
  // just under 4*2^WORD_LEN, so nothing may be truncated before the shift.
  logic [WORD_LEN+1:0] t_add_b;
  logic [WORD_LEN+1:0] t_add_m;

  always_comb begin
    t_add_b = {1'b0, c} + (a_bit ? {2'b00, b} : '0);
    t_add_m = t_add_b + (t_add_b[0] ? {2'b00, m} : '0);
    // t_add_m is even here, so the dropped LSB is always zero.
    c_next  = (WORD_LEN+1)'(t_add_m >> 1);
  end

endmodule

// File: rtl/mont_mult_core.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^(-WORD_LEN) mod M.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   start     : 1-cycle request, honoured only in IDLE
//   in_a/in_b : operands, each < M, sampled when start is accepted
//   in_m      : odd modulus, sampled when start is accepted
//   busy      : high in LOOP and SUB (from the cycle after start until done)
//   done      : 1-cycle pulse in DONE; result valid from this cycle
//   result    : Montgomery product, held until the next accepted start
//   dbg_state : current FSM state encoding
// Handshake: start is accepted only when the FSM is in IDLE (busy=0 and
// done=0); a start seen in any other cycle is dropped, not queued. Each
// accepted start yields exactly one done pulse WORD_LEN+1 edges later.
module mont_mult_core
  import rsa_defs::*;
#(
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORD_LEN-1:0] in_a,
  input  logic [WORD_LEN-1:0] in_b,
  input  logic [WORD_LEN-1:0] in_m,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] result,
  output logic [1:0]          dbg_state
);

  localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  state_e              state;
  state_e              next_state;
  logic [WORD_LEN-1:0] a_q;
  logic [WORD_LEN-1:0] b_q;
  logic [WORD_LEN-1:0] m_q;
  logic [WORD_LEN:0]   c_q;
  logic [WORD_LEN:0]   c_next;
  logic [CW-1:0]       cnt;
  logic                last_iter;
  logic [WORD_LEN-1:0] c_minus_m;
  logic [WORD_LEN-1:0] reduced;

  mont_iter_step #(.WORD_LEN(WORD_LEN)) u_step (
    .c      (c_q),
    .b      (b_q),
    .m      (m_q),
    .a_bit  (a_q[cnt]),
    .c_next (c_next)
  );

  assign last_iter = (cnt == CW'(WORD_LEN - 1));
  assign dbg_state = state;

  // Final conditional subtraction. When C >= M the true difference is below
  // M < 2^WORD_LEN, so a WORD_LEN-bit subtract is exact.
  always_comb begin
    c_minus_m = c_q[WORD_LEN-1:0] - m_q;
    reduced   = (c_q >= {1'b0, m_q}) ? c_minus_m : c_q[WORD_LEN-1:0];
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = LOOP;
      LOOP: if (last_iter) next_state = SUB;
      SUB:  next_state = DONE;
      DONE: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      cnt    <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == LOOP) || (next_state == SUB);
      done  <= (next_state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= in_a;
            b_q <= in_b;
            m_q <= in_m;
            c_q <= '0;
            cnt <= '0;
          end
        end
        LOOP: begin
          c_q <= c_next;
          cnt <= cnt + CW'(1);
        end
        SUB:  result <= reduced;
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mult_core.sv
// Directed bench for mont_mult_core at WORD_LEN = 8, 64 and 512.
// Cycle numbering: start is driven in cycle 0 and sampled at the edge that
// ends it; cycle k is the period after the k-th following edge (cycle 1 is
// the first busy cycle). done is expected in cycle WORD_LEN+2.
module tb_mont_mult_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         start8,   busy8,   done8;
  logic [7:0]   a8,   b8,   m8,   res8;
  logic [1:0]   st8;
  logic         start64,  busy64,  done64;
  logic [63:0]  a64,  b64,  m64,  res64;
  logic [1:0]   st64;
  logic         start512, busy512, done512;
  logic [511:0] a512, b512, m512, res512;
  logic [1:0]   st512;

  int n_cmp = 0;
  int n_err = 0;

  mont_mult_core #(.WORD_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .in_a(a8), .in_b(b8), .in_m(m8),
    .busy(busy8), .done(done8), .result(res8), .dbg_state(st8)
  );
  mont_mult_core #(.WORD_LEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .in_a(a64), .in_b(b64), .in_m(m64),
    .busy(busy64), .done(done64), .result(res64), .dbg_state(st64)
  );
  mont_mult_core #(.WORD_LEN(512)) dut512 (
    .clk(clk), .reset(reset), .start(start512), .in_a(a512), .in_b(b512), .in_m(m512),
    .busy(busy512), .done(done512), .result(res512), .dbg_state(st512)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: reduce A*B mod M, then halve mod M WORD_LEN times.
  function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m, input int w);
    logic [1023:0] p;
    logic [1023:0] mm;
    mm = {512'b0, m};
    p  = {512'b0, a} * {512'b0, b};
    p  = p % mm;
    for (int i = 0; i < w; i++) p = p[0] ? ((p + mm) >> 1) : (p >> 1);
    return p[511:0];
  endfunction

  function automatic int wlen(input int sel);
    case (sel)
      0:       return 8;
      1:       return 64;
      default: return 512;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy8;
      1:       return busy64;
      default: return busy512;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done8;
      1:       return done64;
      default: return done512;
    endcase
  endfunction

  function automatic logic [511:0] get_res(input int sel);
    case (sel)
      0:       return {504'b0, res8};
      1:       return {448'b0, res64};
      default: return res512;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [511:0] a,
                       input logic [511:0] b, input logic [511:0] m);
    case (sel)
      0: begin start8 = s;   a8 = a[7:0];    b8 = b[7:0];    m8 = m[7:0];    end
      1: begin start64 = s;  a64 = a[63:0];  b64 = b[63:0];  m64 = m[63:0];  end
      default: begin start512 = s; a512 = a; b512 = b; m512 = m; end
    endcase
  endtask

  // One operation with latency, busy-window, result and done-width checks.
  // Inputs are scrambled while busy; extra start pulses go in cycles p1/p2.
  task automatic run_op(input int sel, input logic [511:0] a, input logic [511:0] b,
                        input logic [511:0] m, input logic [511:0] exp, input bit chk_res,
                        input string tag, input int p1, input int p2);
    int w;
    int lat;
    bit busy_ok;
    w = wlen(sel);
    @(negedge clk);
    drive(sel, 1'b1, a, b, m);
    @(negedge clk);
    lat = 1;
    busy_ok = 1'b1;
    while (!get_done(sel) && lat < w + 10) begin
      if (!get_busy(sel)) busy_ok = 1'b0;
      drive(sel, (lat == p1) || (lat == p2), ~a, ~b, ~m);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, w + 2);
    check({tag, " busy window"}, busy_ok, 1);
    check({tag, " busy at done"}, get_busy(sel), 0);
    if (chk_res) check({tag, " result"}, get_res(sel), exp);
    drive(sel, (p1 == w + 2) || (p2 == w + 2), a, b, m);
    @(negedge clk);
    drive(sel, 1'b0, a, b, m);
    check({tag, " done width"}, get_done(sel), 0);
    check({tag, " idle after done"}, get_busy(sel), 0);
  endtask

  initial begin
    int lat;
    int gap;
    int extra_done;
    logic [511:0] ta, tb, tm;
    logic [63:0]  ra, rb, rm;

    reset = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    drive(2, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset busy", get_busy(s), 0);
      check("reset done", get_done(s), 0);
      check("reset result", get_res(s), 0);
    end
    check("reset state", st8, 2'd0);

    // Hand-computed at M=241, 2^-8 mod 241 = 225 (0xE1).
    run_op(0, 8'h01, 8'h01, 8'hF1, 8'hE1, 1, "t1 1*1", -1, -1);
    run_op(0, 8'hF0, 8'h01, 8'hF1, 8'h10, 1, "t2 F0*01", -1, -1);
    run_op(0, 8'hF0, 8'hF0, 8'hF1, 8'hE1, 1, "t2 F0*F0", -1, -1);
    run_op(0, 8'h00, 8'hAB, 8'hF1, 8'h00, 1, "t2 A=0", -1, -1);
    run_op(0, 8'h55, 8'h00, 8'hF1, 8'h00, 1, "B=0", -1, -1);
    run_op(0, 8'h10, 8'h10, 8'hF1, 8'h01, 1, "10*10", -1, -1);
    run_op(0, 8'h0F, 8'h01, 8'hF1, 8'h01, 1, "0F*01", -1, -1);

    // Extra starts in cycle 3 (busy) and in the DONE cycle are dropped.
    run_op(0, 8'h01, 8'h01, 8'hF1, 8'hE1, 1, "t4 pulses", 3, 10);
    extra_done = 0;
    repeat (14) begin
      if (done8 || busy8) extra_done++;
      @(negedge clk);
    end
    check("t4 no second op", extra_done, 0);
    check("t4 result held", res8, 8'hE1);

    // Reset in cycle 5 of an operation.
    @(negedge clk);
    drive(0, 1'b1, 8'hF0, 8'h01, 8'hF1);
    @(negedge clk);
    drive(0, 1'b0, 8'hF0, 8'h01, 8'hF1);
    lat = 1;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5 busy after reset", busy8, 0);
    check("t5 done after reset", done8, 0);
    check("t5 result after reset", res8, 8'h00);
    check("t5 state after reset", st8, 2'd0);
    run_op(0, 8'hF0, 8'h01, 8'hF1, 8'h10, 1, "t5 fresh", -1, -1);

    // start held high: back-to-back operations, done every WORD_LEN+3 cycles.
    @(negedge clk);
    drive(0, 1'b1, 8'h01, 8'h01, 8'hF1);
    @(negedge clk);
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("hold first done", lat, 10);
    @(negedge clk);
    gap = 1;
    while (!done8 && gap < 30) begin
      @(negedge clk);
      gap++;
    end
    check("hold done gap", gap, 11);
    drive(0, 1'b0, 8'h01, 8'h01, 8'hF1);
    repeat (3) @(negedge clk);
    check("hold idle", busy8, 0);
    check("hold result", res8, 8'hE1);

    // Out-of-contract operands: only the timing is checked.
    run_op(0, 8'h37, 8'h5A, 8'hF0, '0, 0, "even M", -1, -1);
    run_op(0, 8'hFF, 8'hFE, 8'hF1, '0, 0, "A,B>=M", -1, -1);

    // Wide operands at WORD_LEN=512.
    tm = {16{32'hc6bb131b}} | 512'h1;
    ta = {16{32'h51977946}};
    tb = {16{32'hb220f8c0}};
    run_op(2, ta, tb, tm, mont_ref(ta, tb, tm, 512), 1, "w512 tv", -1, -1);
    run_op(2, '0, tb, tm, '0, 1, "w512 A=0", -1, -1);

    // Random regression at WORD_LEN=64.
    for (int n = 0; n < 1000; n++) begin
      rm = {$urandom, $urandom} | 64'h1;
      ra = {$urandom, $urandom} % rm;
      rb = {$urandom, $urandom} % rm;
      run_op(1, {448'b0, ra}, {448'b0, rb}, {448'b0, rm},
             mont_ref({448'b0, ra}, {448'b0, rb}, {448'b0, rm}, 64), 1, "rand64", -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
